// File: rtl/hr_axis_pkg.sv
// hr_axis_pkg
// Shared types for the haze-removal AXI4-Stream front end.
//   hr_beat_t  - beat payload {data, last, user, pass}, sized for the widest
//                configuration; narrower builds use the low bits of data/pass.
//   PASS_ALE / PASS_TE - pass index of the atmospheric-light pass and the
//                transmission-estimate / refinement pass.
//   hr_clog2   - ceil(log2(value)), 0 for value <= 1.
package hr_axis_pkg;

    localparam int HR_DATA_W_MAX = 64;
    localparam int HR_PASS_W_MAX = 8;

    localparam int PASS_ALE = 0;
    localparam int PASS_TE  = 1;

    typedef struct packed {
        logic [HR_DATA_W_MAX-1:0] data;
        logic                     last;
        logic                     user;
        logic [HR_PASS_W_MAX-1:0] pass;
    } hr_beat_t;

    function automatic int hr_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf
// Two-entry register slice (main + skid) with a registered input ready.
//   ACLK, ARESETn      clock, synchronous active-low reset
//   accept_en_i        when low, s_ready_o drops; stored beats still drain
//   s_data_i/s_valid_i/s_ready_o   upstream handshake
//   m_data_o/m_valid_o/m_ready_i   downstream handshake (m_data_o = main entry)
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    input  logic         accept_en_i,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         in_fire, out_fire;

    assign s_ready_o = ready_q;
    assign m_valid_o = (cnt_q != 2'd0);
    assign m_data_o  = main_q;
    assign in_fire   = s_valid_i && ready_q;
    assign out_fire  = m_valid_o && m_ready_i;

    always_comb begin
        cnt_d  = cnt_q;
        main_d = main_q;
        skid_d = skid_q;
        unique case (cnt_q)
            2'd0: begin
                if (in_fire) begin
                    main_d = s_data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({in_fire, out_fire})
                    2'b11: main_d = s_data_i;           // pass-through, order kept
                    2'b10: begin
                        skid_d = s_data_i;
                        cnt_d  = 2'd2;
                    end
                    2'b01: cnt_d = 2'd0;
                    default: ;
                endcase
            end
            default: begin
                // Full: ready is already low, so only the drain path matters;
                // the in_fire branch keeps the slice safe if that ever changes.
                if (out_fire) begin
                    main_d = skid_q;
                    if (in_fire) skid_d = s_data_i;
                    else         cnt_d  = 2'd1;
                end
            end
        endcase
        // Ready is derived from next occupancy so it can be a flop without
        // ever admitting a third beat.
        ready_d = accept_en_i && (cnt_d != 2'd2);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/axis_frame_pass_seq.sv
// axis_frame_pass_seq
// Frame sequencer in front of the haze-removal core. Counts col/row/pass on
// input handshakes, generates TUSER (start of frame) and TLAST (end of line),
// tags each beat with its pass index and buffers through a 2-entry skid slice.
//   ACLK, ARESETn            clock, synchronous active-low reset
//   enable                   gate for accepting new beats
//   S_AXIS_*                 pixel input; TLAST only checked, never trusted
//   M_AXIS_*                 pixel output with generated TLAST/TUSER
//   pass_idx                 pass of the beat on M_AXIS
//   pass_done / seq_done     1-cycle pulses after last beat of a pass / sequence
//   err_early_last / err_missing_last  sticky TLAST-vs-geometry mismatch flags
module axis_frame_pass_seq
    import hr_axis_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int NUM_PASSES  = 2,
    parameter bit CHECK_TLAST = 1'b1,
    localparam int PASS_W     = (NUM_PASSES > 1) ? hr_clog2(NUM_PASSES) : 1
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              enable,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TVALID,
    input  logic              S_AXIS_TLAST,
    output logic              S_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TUSER,
    input  logic              M_AXIS_TREADY,
    output logic [PASS_W-1:0] pass_idx,
    output logic              pass_done,
    output logic              seq_done,
    output logic              err_early_last,
    output logic              err_missing_last
);

    localparam int COL_W = hr_clog2(IMG_W);
    localparam int ROW_W = (IMG_H > 1) ? hr_clog2(IMG_H) : 1;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              pass_done_q, pass_done_d;
    logic              seq_done_q, seq_done_d;
    logic              early_q, early_d;
    logic              missing_q, missing_d;

    logic     col_last, row_last, pass_last, sof, in_fire;
    hr_beat_t in_beat, out_beat;
    hr_beat_t unused_beat;

    assign col_last  = (col_q == COL_W'(IMG_W - 1));
    assign row_last  = (row_q == ROW_W'(IMG_H - 1));
    assign pass_last = (pass_q == PASS_W'(NUM_PASSES - 1));
    assign sof       = (col_q == '0) && (row_q == '0);
    assign in_fire   = S_AXIS_TVALID && S_AXIS_TREADY;

    // Sideband is captured with the pixel so it stays aligned through stalls.
    always_comb begin
        in_beat                     = '0;
        in_beat.data[DATA_W-1:0]    = S_AXIS_TDATA;
        in_beat.last                = col_last;
        in_beat.user                = sof;
        in_beat.pass[PASS_W-1:0]    = pass_q;
    end

    axis_skid_buf #(
        .W ($bits(hr_beat_t))
    ) u_skid (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .accept_en_i (enable),
        .s_data_i    (in_beat),
        .s_valid_i   (S_AXIS_TVALID),
        .s_ready_o   (S_AXIS_TREADY),
        .m_data_o    (out_beat),
        .m_valid_o   (M_AXIS_TVALID),
        .m_ready_i   (M_AXIS_TREADY)
    );

    // Bits above DATA_W / PASS_W are constant zero and not forwarded.
    assign unused_beat  = out_beat;
    assign M_AXIS_TDATA = out_beat.data[DATA_W-1:0];
    assign M_AXIS_TLAST = out_beat.last;
    assign M_AXIS_TUSER = out_beat.user;
    assign pass_idx     = out_beat.pass[PASS_W-1:0];

    assign pass_done        = pass_done_q;
    assign seq_done         = seq_done_q;
    assign err_early_last   = early_q;
    assign err_missing_last = missing_q;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pass_d      = pass_q;
        pass_done_d = 1'b0;
        seq_done_d  = 1'b0;
        early_d     = early_q;
        missing_d   = missing_q;
        if (in_fire) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d       = '0;
                    pass_done_d = 1'b1;
                    if (pass_last) begin
                        pass_d     = '0;
                        seq_done_d = 1'b1;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
            // Clear on the first beat of a sequence, then let a fresh error
            // on that same beat override the clear.
            if (sof && (pass_q == '0)) begin
                early_d   = 1'b0;
                missing_d = 1'b0;
            end
            if (CHECK_TLAST) begin
                if (S_AXIS_TLAST && !col_last) early_d   = 1'b1;
                if (!S_AXIS_TLAST && col_last) missing_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            col_q       <= '0;
            row_q       <= '0;
            pass_q      <= '0;
            pass_done_q <= 1'b0;
            seq_done_q  <= 1'b0;
            early_q     <= 1'b0;
            missing_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pass_q      <= pass_d;
            pass_done_q <= pass_done_d;
            seq_done_q  <= seq_done_d;
            early_q     <= early_d;
            missing_q   <= missing_d;
        end
    end

endmodule

// File: tb/tb_axis_frame_pass_seq.sv
// Bench for axis_frame_pass_seq: 4x2 frame, two builds side by side
// (NUM_PASSES=2/CHECK_TLAST=1 and NUM_PASSES=1/CHECK_TLAST=0) sharing inputs.
module tb_axis_frame_pass_seq;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int NP    = 2;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        enable = 1'b1;
    logic [31:0] S_AXIS_TDATA = '0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TLAST = 1'b0;
    logic        M_AXIS_TREADY = 1'b1;

    logic        S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER;
    logic [31:0] M_AXIS_TDATA;
    logic [0:0]  pass_idx;
    logic        pass_done, seq_done, err_early_last, err_missing_last;

    logic        s_rdy1, m_vld1, m_last1, m_user1;
    logic [31:0] m_data1;
    logic [0:0]  pidx1;
    logic        pd1, sd1, ee1, em1;

    always #5 ACLK = ~ACLK;

    axis_frame_pass_seq #(.DATA_W(32), .IMG_W(IMG_W), .IMG_H(IMG_H),
                          .NUM_PASSES(NP), .CHECK_TLAST(1'b1)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TUSER(M_AXIS_TUSER),
        .M_AXIS_TREADY(M_AXIS_TREADY), .pass_idx(pass_idx),
        .pass_done(pass_done), .seq_done(seq_done),
        .err_early_last(err_early_last), .err_missing_last(err_missing_last));

    axis_frame_pass_seq #(.DATA_W(32), .IMG_W(IMG_W), .IMG_H(IMG_H),
                          .NUM_PASSES(1), .CHECK_TLAST(1'b0)) dut1 (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(s_rdy1),
        .M_AXIS_TDATA(m_data1), .M_AXIS_TVALID(m_vld1),
        .M_AXIS_TLAST(m_last1), .M_AXIS_TUSER(m_user1),
        .M_AXIS_TREADY(M_AXIS_TREADY), .pass_idx(pidx1),
        .pass_done(pd1), .seq_done(sd1),
        .err_early_last(ee1), .err_missing_last(em1));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
        logic        p;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   col = 0, row = 0, pas = 0, cyc = 0;
    logic e_pd = 0, e_sd = 0, e_pd1 = 0, e_ee = 0, e_em = 0, exp_rdy = 0;
    logic mon_on = 0, lat_chk = 0, tog_mode = 0;
    int   out_cnt = 0, pd_cnt = 0, sd_cnt = 0;
    int   ph = 0, bn = 0, flip_a = -1, flip_b = -1;

    // Scoreboard: checks at negedge what the next posedge will see, then
    // advances the reference model for that edge.
    always @(negedge ACLK) begin
        exp_t e;
        if (mon_on) begin
            chk("s_ready", S_AXIS_TREADY, exp_rdy);
            chk("s_ready1", s_rdy1, exp_rdy);
            chk("m_valid", M_AXIS_TVALID, q.size() != 0);
            chk("m_valid1", m_vld1, q.size() != 0);
            chk("pass_done", pass_done, e_pd);
            chk("seq_done", seq_done, e_sd);
            chk("err_early", err_early_last, e_ee);
            chk("err_missing", err_missing_last, e_em);
            chk("pass_done1", pd1, e_pd1);
            chk("seq_done1", sd1, e_pd1);
            chk("pass_idx1", pidx1, 0);
            chk("err_early1", ee1, 0);
            chk("err_missing1", em1, 0);
            if (M_AXIS_TVALID && q.size() != 0) begin
                chk("tdata", M_AXIS_TDATA, q[0].d);
                chk("tlast", M_AXIS_TLAST, q[0].l);
                chk("tuser", M_AXIS_TUSER, q[0].u);
                chk("pass_idx", pass_idx, q[0].p);
                chk("tdata1", m_data1, q[0].d);
                chk("tlast1", m_last1, q[0].l);
                chk("tuser1", m_user1, q[0].u);
                if (M_AXIS_TREADY) begin
                    if (lat_chk) chk("latency", cyc - q[0].cyc, 1);
                    out_cnt++;
                    void'(q.pop_front());
                end
            end
            if (pass_done) pd_cnt++;
            if (seq_done) sd_cnt++;
        end
        if (!ARESETn) begin
            q.delete();
            col = 0; row = 0; pas = 0;
            e_pd = 0; e_sd = 0; e_pd1 = 0; e_ee = 0; e_em = 0; exp_rdy = 0;
        end else begin
            e_pd = 0; e_sd = 0; e_pd1 = 0;
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                e.d = S_AXIS_TDATA;
                e.l = (col == IMG_W - 1);
                e.u = (col == 0 && row == 0);
                e.p = (pas == 1);
                e.cyc = cyc;
                q.push_back(e);
                if (col == 0 && row == 0 && pas == 0) begin e_ee = 0; e_em = 0; end
                if (S_AXIS_TLAST && col != IMG_W - 1) e_ee = 1;
                if (!S_AXIS_TLAST && col == IMG_W - 1) e_em = 1;
                if (col == IMG_W - 1 && row == IMG_H - 1) e_pd1 = 1;
                if (col == IMG_W - 1) begin
                    col = 0;
                    if (row == IMG_H - 1) begin
                        row = 0;
                        e_pd = 1;
                        if (pas == NP - 1) begin pas = 0; e_sd = 1; end
                        else pas++;
                    end else row++;
                end else col++;
            end
            exp_rdy = enable && (q.size() < 2);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
        if (tog_mode) begin
            M_AXIS_TREADY = (ph == 0);
            ph = (ph + 1) % 3;
        end
    endtask

    task automatic send(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = $urandom();
            S_AXIS_TLAST  = ((bn % IMG_W) == IMG_W - 1) ^ (k == flip_a) ^ (k == flip_b);
            t = 0;
            @(negedge ACLK);
            while (!S_AXIS_TREADY && t < 200) begin
                tick();
                @(negedge ACLK);
                t++;
            end
            if (t >= 200) chk("send_timeout", S_AXIS_TREADY, 1);
            tick();
            bn++;
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        @(negedge ACLK);
        while (q.size() != 0 && t < 200) begin
            tick();
            @(negedge ACLK);
            t++;
        end
        chk("drain", q.size(), 0);
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, S_AXIS_TREADY, 0);
        chk({tag, "_m_valid"}, M_AXIS_TVALID, 0);
        chk({tag, "_tdata"}, M_AXIS_TDATA, 0);
        chk({tag, "_tlast"}, M_AXIS_TLAST, 0);
        chk({tag, "_tuser"}, M_AXIS_TUSER, 0);
        chk({tag, "_pass_idx"}, pass_idx, 0);
        chk({tag, "_pass_done"}, pass_done, 0);
        chk({tag, "_seq_done"}, seq_done, 0);
        chk({tag, "_err_early"}, err_early_last, 0);
        chk({tag, "_err_missing"}, err_missing_last, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, p0, s0;
        // reset
        tick(); tick();
        mon_on = 1;
        tick();
        @(negedge ACLK);
        chk_reset_vals("rst");
        ARESETn = 1'b1;
        tick();

        // 1: back-to-back, 1-cycle latency
        o0 = out_cnt; p0 = pd_cnt; s0 = sd_cnt;
        lat_chk = 1;
        send(16);
        wait_drain();
        lat_chk = 0;
        chk("t1_nout", out_cnt - o0, 16);
        chk("t1_pass_done", pd_cnt - p0, 2);
        chk("t1_seq_done", sd_cnt - s0, 1);

        // 2: output ready 1-high/2-low
        o0 = out_cnt;
        ph = 0;
        tog_mode = 1;
        send(16);
        wait_drain();
        tog_mode = 0;
        M_AXIS_TREADY = 1'b1;
        chk("t2_nout", out_cnt - o0, 16);

        // 3: early TLAST on beat 1, missing TLAST on beat 3
        flip_a = 1; flip_b = 3;
        send(4);
        flip_a = -1; flip_b = -1;
        @(negedge ACLK);
        chk("t3_early", err_early_last, 1);
        chk("t3_missing", err_missing_last, 1);
        tick();
        send(12);
        @(negedge ACLK);
        chk("t3_early_held", err_early_last, 1);
        tick();

        // 4: enable drop after beat 5
        send(1);
        @(negedge ACLK);
        chk("t4_early_clr", err_early_last, 0);
        chk("t4_missing_clr", err_missing_last, 0);
        tick();
        send(5);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge ACLK);
            chk("t4_ready_low", S_AXIS_TREADY, 0);
        end
        chk("t4_drained", M_AXIS_TVALID, 0);
        enable = 1'b1;
        tick();
        send(10);
        wait_drain();

        // 5: reset pulse after beat 9
        send(10);
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk_reset_vals("t5");
        tick();
        bn = 0;
        send(4);
        wait_drain();

        // dut1 (single pass, no TLAST check) is compared every cycle above
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
